// File: rtl/cfs_aligner_stream.sv
// -----------------------------------------------------------------------------
// cfs_aligner_stream
//
// Re-packs a stream of byte-granular inbound transfers into outbound transfers
// of a configured byte size and byte offset. Inbound bytes are appended to a
// 2N-byte accumulator (byte 0 oldest). When enough bytes are buffered and the
// configuration is legal, the oldest cfg_size bytes are registered into the
// outbound word at byte lane cfg_offset and held until the sink accepts them.
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   cfg_offset, cfg_size    : target byte offset / size of outbound transfers
//   cfg_clr                 : one-cycle pulse, clears cnt_drop
//   cfg_err                 : configuration illegal (combinational)
//   md_rx_*                 : inbound valid/ready stream; md_rx_err flags an
//                             illegal transfer in its accept cycle
//   md_tx_*                 : outbound valid/ready stream; md_tx_err is the
//                             sink error flag sampled in the handshake cycle
//   cnt_drop                : saturating count of dropped inbound transfers
//   irq_drop, irq_tx_err    : one-cycle event pulses
// -----------------------------------------------------------------------------
module cfs_aligner_stream #(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int DROP_CNT_WIDTH  = 8,
  localparam int N  = ALGN_DATA_WIDTH / 8,
  localparam int OW = (N == 1) ? 1 : $clog2(N),
  localparam int SW = $clog2(N) + 1,
  localparam int CW = $clog2(2 * N) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [OW-1:0]              cfg_offset,
  input  logic [SW-1:0]              cfg_size,
  input  logic                       cfg_clr,
  input  logic                       md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
  input  logic [OW-1:0]              md_rx_offset,
  input  logic [SW-1:0]              md_rx_size,
  output logic                       md_rx_ready,
  output logic                       md_rx_err,
  output logic                       md_tx_valid,
  output logic [ALGN_DATA_WIDTH-1:0] md_tx_data,
  output logic [OW-1:0]              md_tx_offset,
  output logic [SW-1:0]              md_tx_size,
  input  logic                       md_tx_ready,
  input  logic                       md_tx_err,
  output logic                       cfg_err,
  output logic [DROP_CNT_WIDTH-1:0]  cnt_drop,
  output logic                       irq_drop,
  output logic                       irq_tx_err
);

  localparam int DW = ALGN_DATA_WIDTH;
  localparam int BW = 2 * N * 8;
  localparam logic [SW:0] N_EXT = (SW + 1)'(N);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] v
  );
    if (&v) begin
      return v;
    end
    return v + DROP_CNT_WIDTH'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                    state_q, state_d;
  logic [BW-1:0]             buf_q, buf_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DW-1:0]             tx_data_q, tx_data_d;
  logic [OW-1:0]             tx_offset_q, tx_offset_d;
  logic [SW-1:0]             tx_size_q, tx_size_d;
  logic [DROP_CNT_WIDTH-1:0] cnt_drop_q, cnt_drop_d;
  logic                      irq_drop_q, irq_drop_d;
  logic                      irq_tx_err_q, irq_tx_err_d;

  // ---------------------------------------------------------------------------
  // Inbound legality and handshake
  // ---------------------------------------------------------------------------
  logic [SW:0]   rx_end;
  logic          rx_legal;
  logic          rx_ready;
  logic          rx_accept;
  logic          rx_push;

  // Extra bit on rx_end keeps offset+size from wrapping.
  assign rx_end    = (SW + 1)'(md_rx_offset) + (SW + 1)'(md_rx_size);
  assign rx_legal  = (md_rx_size != '0) && (rx_end <= N_EXT);
  // Ready is decoded from registered occupancy only, so it never combinationally
  // depends on md_rx_valid.
  assign rx_ready  = (cnt_q <= CW'(N));
  assign rx_accept = md_rx_valid & rx_ready;
  assign rx_push   = rx_accept & rx_legal;

  assign md_rx_ready = rx_ready;
  assign md_rx_err   = rx_accept & ~rx_legal;

  // ---------------------------------------------------------------------------
  // Configuration check
  // ---------------------------------------------------------------------------
  logic [SW:0]   cfg_end;
  logic [SW:0]   cfg_phase;
  logic [SW-1:0] cfg_div;
  logic [SW:0]   cfg_rem;

  assign cfg_end   = (SW + 1)'(cfg_offset) + (SW + 1)'(cfg_size);
  // A repeating pattern of cfg_size-byte chunks placed at cfg_offset must tile
  // the bus; (N + offset) mod size == 0 expresses that.
  assign cfg_phase = N_EXT + (SW + 1)'(cfg_offset);
  assign cfg_div   = (cfg_size == '0) ? SW'(1) : cfg_size;
  assign cfg_rem   = cfg_phase % (SW + 1)'(cfg_div);
  assign cfg_err   = (cfg_size == '0) || (cfg_end > N_EXT) || (cfg_rem != '0);

  // ---------------------------------------------------------------------------
  // Accumulator datapath
  // ---------------------------------------------------------------------------
  logic          load;
  logic [SW+2:0] ld_shift;
  logic [BW-1:0] buf_sh;
  logic [CW-1:0] cnt_sh;
  logic [DW-1:0] rx_aligned;
  logic [DW-1:0] rx_mask;
  logic [DW-1:0] rx_bytes;
  logic [BW-1:0] rx_ins;
  logic [DW-1:0] tx_mask;
  logic [DW-1:0] tx_load_data;

  assign load = (state_q == IDLE) && (cnt_q >= CW'(cfg_size)) && !cfg_err;

  // Bytes above cnt are kept at zero, so removing the emitted bytes is a plain
  // right shift and appending is an OR of the new bytes at the new fill level.
  assign ld_shift = load ? {cfg_size, 3'b000} : '0;
  assign buf_sh   = buf_q >> ld_shift;
  assign cnt_sh   = cnt_q - (load ? CW'(cfg_size) : '0);

  // Shifting by a full bus width yields zero, so size == N gives an all-ones mask.
  assign rx_aligned = md_rx_data >> {md_rx_offset, 3'b000};
  assign rx_mask    = ~({DW{1'b1}} << {md_rx_size, 3'b000});
  assign rx_bytes   = rx_aligned & rx_mask;
  assign rx_ins     = BW'(rx_bytes) << {cnt_sh, 3'b000};

  assign buf_d = buf_sh | (rx_push ? rx_ins : '0);
  assign cnt_d = cnt_sh + (rx_push ? CW'(md_rx_size) : '0);

  assign tx_mask      = ~({DW{1'b1}} << {cfg_size, 3'b000});
  assign tx_load_data = (buf_q[DW-1:0] & tx_mask) << {cfg_offset, 3'b000};

  // ---------------------------------------------------------------------------
  // Output FSM and event logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_offset_d = tx_offset_q;
    tx_size_d   = tx_size_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d     = VALID;
          tx_data_d   = tx_load_data;
          tx_offset_d = cfg_offset;
          tx_size_d   = cfg_size;
        end
      end
      VALID: begin
        if (md_tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_tx_err_d = (state_q == VALID) & md_tx_ready & md_tx_err;
    irq_drop_d   = md_rx_err;
    cnt_drop_d   = cnt_drop_q;
    // A clear coinciding with a drop leaves that drop counted.
    if (cfg_clr) begin
      cnt_drop_d = md_rx_err ? DROP_CNT_WIDTH'(1) : '0;
    end else if (md_rx_err) begin
      cnt_drop_d = sat_inc(cnt_drop_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_offset_q  <= '0;
      tx_size_q    <= '0;
      cnt_drop_q   <= '0;
      irq_drop_q   <= 1'b0;
      irq_tx_err_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_offset_q  <= tx_offset_d;
      tx_size_q    <= tx_size_d;
      cnt_drop_q   <= cnt_drop_d;
      irq_drop_q   <= irq_drop_d;
      irq_tx_err_q <= irq_tx_err_d;
    end
  end

  assign md_tx_valid  = (state_q == VALID);
  assign md_tx_data   = tx_data_q;
  assign md_tx_offset = tx_offset_q;
  assign md_tx_size   = tx_size_q;
  assign cnt_drop     = cnt_drop_q;
  assign irq_drop     = irq_drop_q;
  assign irq_tx_err   = irq_tx_err_q;

endmodule
